apb_timer_irq_ctrl: RTL and testbench
=====================================

# apb_timer_irq_ctrl

Interrupt controller for the timer subsystem: collects the per-timer overflow and compare interrupt lines, latches them as pending events and applies a per-source enable mask. It round-robin arbitrates among enabled pending sources and presents one interrupt plus winning source ID to the core, with a claim/complete handshake over APB. It sits on its own APB slot beside the timer array and consumes its `irq_o` vector directly.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width.
- `TIMER_CNT`, 2, number of timers. Sources `NSRC = 2*TIMER_CNT`, limited to 2..30. `ID_W = $clog2(NSRC)`.

Ports:
- `HCLK` in 1: the only clock.
- `HRESET` in 1: reset, synchronous and active-high.
- `PADDR` in APB_ADDR_WIDTH: APB address.
- `PWDATA` in 32: write data.
- `PWRITE` in 1: write strobe.
- `PSEL` in 1: slave select.
- `PENABLE` in 1: access phase.
- `PRDATA` out 32: read data.
- `PREADY` out 1: ready.
- `PSLVERR` out 1: error.
- `irq_i` in NSRC: timer interrupts. Bit `2k` is timer k overflow; bit `2k+1` is timer k compare.
- `irq_o` out 1: interrupt request to the core.
- `irq_id_o` out ID_W: current arbitration winner.

## Operation
- **Access and errors.** An APB access occurs on a cycle with `PSEL & PENABLE`. The register select is `PADDR[3:2]`. Any access with `PADDR[APB_ADDR_WIDTH-1:4] != 0` is an error: `PSLVERR=1`, no side effects, `PRDATA=0`.
- **0x0 PENDING (RO).**
  - A read returns `pending[NSRC-1:0]`, zero-extended.
  - A write has no effect and sets `PSLVERR=1`.
- **0x4 MASK (RW).** 1 enables a source. Bits at position NSRC and above are ignored on write and read as 0.
- **0x8 CLAIM/COMPLETE.**
  - Read in IDLE with at least one candidate:
    - returns `{1'b1, 31-ID_W zeros, winner}`;
    - clears `pending[winner]`;
    - sets `claimed_id = winner` and `ptr = (winner+1) mod NSRC`;
    - moves to CLAIMED.
  - Read in IDLE with no candidate returns 0 and changes nothing.
  - Read in CLAIMED returns `{1'b1, claimed_id}` and has no side effect.
  - Write in CLAIMED with `PWDATA[ID_W-1:0] == claimed_id` and upper bits 0 moves to IDLE.
  - Any other write (wrong ID, or state IDLE) sets `PSLVERR=1` and changes nothing.
- **0xC PEND_CLR (WO).** Writing 1 clears the matching pending bits. A read returns 0 with no error.
- **Edge capture.** `irq_q` is a registered copy of `irq_i` (reset 0). `pending[i]` is set when `irq_i[i] & ~irq_q[i]`.
  - Set wins over a claim-clear or PEND_CLR of the same bit in the same cycle.
  - A source held high through reset release counts as one edge.
- **Candidates.** `cand = pending & mask`.
  - `winner` is the first set bit of `cand` searching upward from `ptr`, wrapping at NSRC.
  - `winner = 0` when `cand == 0`.
- **State machine.**
  - IDLE goes to CLAIMED on a successful claim read.
  - CLAIMED goes to IDLE on a matching complete write.
  - There are no other transitions.
- **Outputs.**
  - `irq_o = (state==IDLE) & |cand`.
  - `irq_id_o = winner`, output in both states.
  - Both are combinational from registers only, with no APB-input paths.
- **Mask behaviour.** Masking a pending source does not clear it; unmasking re-raises `irq_o`.
- **Reset (HRESET=1 at a rising edge, any state, including mid-claim):**
  - pending=0, mask=0, ptr=0, claimed_id=0, state=IDLE, irq_q=0;
  - outputs `irq_o=0`, `irq_id_o=0`, `PRDATA=0`, `PREADY=1`, `PSLVERR=0`.

## Timing
- **APB.** Zero wait states: `PREADY=1` always.
  - `PRDATA` and `PSLVERR` are combinational, valid only in the access cycle.
  - `PRDATA=0` and `PSLVERR=0` outside access cycles.
  - Register updates take effect at the end of the access cycle.
- **Interrupt latency.** A rising edge of `irq_i[i]` sampled at edge N (with irq_q=0) gives `pending[i]=1` from cycle N+1. If masked-in and in IDLE, `irq_o=1` from cycle N+1.
- **Claim.** For a claim in access cycle M: `irq_o=0` from cycle M+1, and the new `ptr` applies from M+1.
- **Complete.** For a complete in access cycle M with other candidates present: `irq_o=1` from M+1 with the next round-robin winner.
- **Re-trigger.** The same source re-firing while claimed re-pends it. It is served after completion, subject to round-robin order.

## Test plan
All scenarios use TIMER_CNT=2, so NSRC=4.
- **Reset.** Hold HRESET 2 cycles with `irq_i=0` -> all reads return 0, `irq_o=0`, `irq_id_o=0`, `PREADY=1`.
- **Single source.** MASK=0xF, then pulse `irq_i[1]` for 1 cycle.
  - `irq_o=1` and `irq_id_o=1` one cycle after the pulse.
  - CLAIM read returns 0x80000001; `irq_o=0` next cycle.
  - Writing 1 to 0x8 returns to IDLE with `irq_o=0`.
- **Round robin.** Pulse `irq_i=4'b1011` simultaneously, then loop claim/complete.
  - Claim order is 0, 1, 3.
  - Re-pulse bits 0 and 1 after claiming 0 -> the order continues 1, 3, then 0.
- **Mask and clear.** MASK=0, pulse bit 2.
  - PENDING=0x4 and `irq_o=0`.
  - MASK=0x4 -> `irq_o=1`.
  - PEND_CLR write 0x4 -> PENDING=0 and `irq_o=0`.
  - Write PEND_CLR 0x4 in the same cycle as a new edge on bit 2 -> PENDING=0x4.
- **Errors.**
  - Complete with ID 2 while claimed_id=1 -> `PSLVERR=1`, state stays CLAIMED.
  - Complete in IDLE -> `PSLVERR=1`.
  - Access at 0x10 -> `PSLVERR=1`, `PRDATA=0`.
  - Write 0x0 -> `PSLVERR=1`.
- **Reset mid-claim.** Claim source 3, then assert HRESET for 1 cycle -> state IDLE, PENDING=0, MASK=0, and the next claim read returns 0.

Source files
------------

// File: rtl/apb_timer_irq_ctrl.sv
// Timer interrupt controller: edge-captured pending bits, per-source mask,
// round-robin arbitration and an APB claim/complete handshake.
module apb_timer_irq_ctrl #(
    parameter  int APB_ADDR_WIDTH = 12,
    parameter  int TIMER_CNT      = 2,
    localparam int NSRC           = 2 * TIMER_CNT,
    localparam int ID_W           = $clog2(NSRC)
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NSRC-1:0]           irq_i,
    output logic                      irq_o,
    output logic [ID_W-1:0]           irq_id_o
);

    typedef enum logic {
        S_IDLE,
        S_CLAIMED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] irq_q;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] claimed_id;

    logic            acc;
    logic            addr_err;
    logic            rd_ok;
    logic            wr_ok;
    logic            sel_pend;
    logic            sel_mask;
    logic            sel_claim;
    logic            sel_pclr;
    logic            claim;
    logic            cmpl;
    logic            id_match;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] claim_clr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] ptr_nxt;
    logic            addr_unused;

    assign addr_unused = ^PADDR[1:0];

    assign acc       = PSEL & PENABLE;
    assign addr_err  = |PADDR[APB_ADDR_WIDTH-1:4];
    assign rd_ok     = acc & ~addr_err & ~PWRITE;
    assign wr_ok     = acc & ~addr_err & PWRITE;
    assign sel_pend  = (PADDR[3:2] == 2'd0);
    assign sel_mask  = (PADDR[3:2] == 2'd1);
    assign sel_claim = (PADDR[3:2] == 2'd2);
    assign sel_pclr  = (PADDR[3:2] == 2'd3);

    assign cand = pending & mask;

    // Round-robin search: first candidate at or above ptr, wrapping at NSRC.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NSRC; k++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NSRC)) begin
                sum = sum - (ID_W + 1)'(NSRC);
            end
            idx = sum[ID_W-1:0];
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign id_match = (PWDATA[ID_W-1:0] == claimed_id)
                    & ~|PWDATA[31:ID_W];
    assign claim = rd_ok & sel_claim & (state == S_IDLE) & found;
    assign cmpl  = wr_ok & sel_claim & (state == S_CLAIMED) & id_match;

    assign ptr_nxt = (winner == ID_W'(NSRC - 1)) ? '0 : winner + 1'b1;

    assign rise      = irq_i & ~irq_q;
    assign clr       = (wr_ok & sel_pclr) ? PWDATA[NSRC-1:0] : '0;
    assign claim_clr = claim ? (NSRC'(1) << winner) : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (claim) state_nxt = S_CLAIMED;
            S_CLAIMED: if (cmpl)  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= S_IDLE;
            pending    <= '0;
            mask       <= '0;
            irq_q      <= '0;
            ptr        <= '0;
            claimed_id <= '0;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq_i;
            // A fresh edge outranks any clear of the same bit.
            pending <= (pending & ~clr & ~claim_clr) | rise;
            if (wr_ok && sel_mask) begin
                mask <= PWDATA[NSRC-1:0];
            end
            if (claim) begin
                claimed_id <= winner;
                ptr        <= ptr_nxt;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_ok) begin
            unique case (1'b1)
                sel_pend: PRDATA = 32'(pending);
                sel_mask: PRDATA = 32'(mask);
                sel_claim: begin
                    if (state == S_CLAIMED) begin
                        PRDATA     = 32'(claimed_id);
                        PRDATA[31] = 1'b1;
                    end else if (found) begin
                        PRDATA     = 32'(winner);
                        PRDATA[31] = 1'b1;
                    end
                end
                default: PRDATA = '0;
            endcase
        end
    end

    assign PSLVERR = acc & (addr_err
                   | (PWRITE & sel_pend)
                   | (PWRITE & sel_claim & ~cmpl));
    assign PREADY  = 1'b1;

    assign irq_o    = (state == S_IDLE) & |cand;
    assign irq_id_o = winner;

endmodule

// File: tb/tb_apb_timer_irq_ctrl.sv
// Directed bench for apb_timer_irq_ctrl with TIMER_CNT=2 (four sources):
// a cycle-per-entry vector table plus hand sequences around reset.
module tb_apb_timer_irq_ctrl;

    localparam int IDL = 0;
    localparam int RD  = 1;
    localparam int WR  = 2;

    typedef struct {
        int          op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  irq;
        logic [31:0] rd;
        logic        err;
        logic        irq_o;
        logic [1:0]  id;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  irq_i;
    logic        irq_o;
    logic [1:0]  irq_id_o;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 HCLK = ~HCLK;

    apb_timer_irq_ctrl #(
        .APB_ADDR_WIDTH(12),
        .TIMER_CNT     (2)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq_i   (irq_i),
        .irq_o   (irq_o),
        .irq_id_o(irq_id_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input int op, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [3:0] irq,
                       input logic [31:0] rd, input logic err,
                       input logic io, input logic [1:0] id);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.irq = irq;
        v.rd = rd; v.err = err; v.irq_o = io; v.id = id;
        tbl.push_back(v);
    endtask

    // One clock: drive, sample at the falling edge, step past the rise.
    task automatic cyc(input string tag, input vec_t v);
        PSEL    = (v.op != IDL);
        PENABLE = (v.op != IDL);
        PWRITE  = (v.op == WR);
        PADDR   = v.addr;
        PWDATA  = v.wdata;
        irq_i   = v.irq;
        @(negedge HCLK);
        chk({tag, " prdata"},  PRDATA, v.rd);
        chk({tag, " pslverr"}, 32'(PSLVERR), 32'(v.err));
        chk({tag, " pready"},  32'(PREADY), 32'd1);
        chk({tag, " irq_o"},   32'(irq_o), 32'(v.irq_o));
        chk({tag, " irq_id"},  32'(irq_id_o), 32'(v.id));
        @(posedge HCLK);
        #1;
    endtask

    task automatic one(input string tag, input int op,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] irq, input logic [31:0] rd,
                       input logic err, input logic io,
                       input logic [1:0] id);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.irq = irq;
        v.rd = rd; v.err = err; v.irq_o = io; v.id = id;
        cyc(tag, v);
    endtask

    task automatic pulse_reset(input logic [3:0] irq);
        HRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        irq_i   = irq;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    initial begin
        HRESET  = 1'b1;
        PADDR   = '0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        irq_i   = '0;
        @(posedge HCLK);
        @(negedge HCLK);
        chk("rst irq_o",   32'(irq_o), 32'd0);
        chk("rst irq_id",  32'(irq_id_o), 32'd0);
        chk("rst pready",  32'(PREADY), 32'd1);
        chk("rst prdata",  PRDATA, 32'd0);
        chk("rst pslverr", 32'(PSLVERR), 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // reset-state reads
        add(RD,  12'h000, 0, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h004, 0, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h008, 0, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h00C, 0, 4'h0, 32'h0, 0, 0, 0);
        // round robin: 0, 1, re-pend 0/1, then 3, 0
        add(WR,  12'h004, 32'hF, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h004, 0, 4'h0, 32'hF, 0, 0, 0);
        add(WR,  12'h004, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h004, 0, 4'h0, 32'hF, 0, 0, 0);
        add(IDL, 12'h000, 0, 4'hB, 32'h0, 0, 0, 0);
        add(IDL, 12'h000, 0, 4'h0, 32'h0, 0, 1, 0);
        add(RD,  12'h000, 0, 4'h0, 32'hB, 0, 1, 0);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0000, 0, 1, 0);
        add(IDL, 12'h000, 0, 4'h3, 32'h0, 0, 0, 1);
        add(IDL, 12'h000, 0, 4'h0, 32'h0, 0, 0, 1);
        add(WR,  12'h008, 32'h0, 4'h0, 32'h0, 0, 0, 1);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0001, 0, 1, 1);
        add(WR,  12'h008, 32'h1, 4'h0, 32'h0, 0, 0, 3);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0003, 0, 1, 3);
        add(WR,  12'h008, 32'h3, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0000, 0, 1, 0);
        add(WR,  12'h008, 32'h0, 4'h0, 32'h0, 0, 0, 0);
        // single source, wrong-ID completes
        add(IDL, 12'h000, 0, 4'h2, 32'h0, 0, 0, 0);
        add(IDL, 12'h000, 0, 4'h0, 32'h0, 0, 1, 1);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0001, 0, 1, 1);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0001, 0, 0, 0);
        add(WR,  12'h008, 32'h2, 4'h0, 32'h0, 1, 0, 0);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0001, 0, 0, 0);
        add(WR,  12'h008, 32'h5, 4'h0, 32'h0, 1, 0, 0);
        add(WR,  12'h008, 32'h1, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h008, 0, 4'h0, 32'h0, 0, 0, 0);
        add(WR,  12'h008, 32'h1, 4'h0, 32'h0, 1, 0, 0);
        // mask and pending clear
        add(WR,  12'h004, 32'h0, 4'h0, 32'h0, 0, 0, 0);
        add(IDL, 12'h000, 0, 4'h4, 32'h0, 0, 0, 0);
        add(IDL, 12'h000, 0, 4'h0, 32'h0, 0, 0, 0);
        add(RD,  12'h000, 0, 4'h0, 32'h4, 0, 0, 0);
        add(WR,  12'h004, 32'h4, 4'h0, 32'h0, 0, 0, 0);
        add(IDL, 12'h000, 0, 4'h0, 32'h0, 0, 1, 2);
        add(WR,  12'h00C, 32'h4, 4'h0, 32'h0, 0, 1, 2);
        add(RD,  12'h000, 0, 4'h0, 32'h0, 0, 0, 0);
        add(WR,  12'h00C, 32'h4, 4'h4, 32'h0, 0, 0, 0);
        add(RD,  12'h000, 0, 4'h4, 32'h4, 0, 1, 2);
        add(RD,  12'h00C, 0, 4'h0, 32'h0, 0, 1, 2);
        // errors
        add(RD,  12'h010, 0, 4'h0, 32'h0, 1, 1, 2);
        add(WR,  12'h014, 32'h0, 4'h0, 32'h0, 1, 1, 2);
        add(RD,  12'h004, 0, 4'h0, 32'h4, 0, 1, 2);
        add(WR,  12'h000, 32'h0, 4'h0, 32'h0, 1, 1, 2);
        add(RD,  12'h000, 0, 4'h0, 32'h4, 0, 1, 2);
        add(RD,  12'h018, 0, 4'h0, 32'h0, 1, 1, 2);
        add(RD,  12'h008, 0, 4'h0, 32'h8000_0002, 0, 1, 2);
        add(WR,  12'h00C, 32'h0, 4'h0, 32'h0, 0, 0, 0);

        foreach (tbl[i]) begin
            cyc($sformatf("v%0d", i), tbl[i]);
        end

        // reset while source 3 is claimed
        one("h0",  WR,  12'h008, 32'h2, 4'h0, 32'h0, 0, 0, 0);
        one("h1",  WR,  12'h004, 32'hF, 4'h0, 32'h0, 0, 0, 0);
        one("h2",  IDL, 12'h000, 0, 4'h8, 32'h0, 0, 0, 0);
        one("h3",  IDL, 12'h000, 0, 4'h0, 32'h0, 0, 1, 3);
        one("h4",  RD,  12'h008, 0, 4'h0, 32'h8000_0003, 0, 1, 3);
        pulse_reset(4'h0);
        one("h5",  RD,  12'h000, 0, 4'h0, 32'h0, 0, 0, 0);
        one("h6",  RD,  12'h004, 0, 4'h0, 32'h0, 0, 0, 0);
        one("h7",  RD,  12'h008, 0, 4'h0, 32'h0, 0, 0, 0);
        one("h8",  WR,  12'h008, 32'h3, 4'h0, 32'h0, 1, 0, 0);

        // source high across reset release is a single edge
        pulse_reset(4'h1);
        one("h9",  IDL, 12'h000, 0, 4'h1, 32'h0, 0, 0, 0);
        one("h10", RD,  12'h000, 0, 4'h1, 32'h1, 0, 0, 0);
        one("h11", WR,  12'h00C, 32'h1, 4'h1, 32'h0, 0, 0, 0);
        one("h12", RD,  12'h000, 0, 4'h1, 32'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
